// File: rtl/frontend_mem_responder.sv
// frontend_mem_responder: array-backed stand-in for the command scheduler and DRAM backend,
// with fixed read latency, an outstanding-read credit limit, command gaps and refresh stalls.
`ifndef DQ_BITS
`define DQ_BITS 8
`endif
package frontend_pkg;
  typedef enum logic [1:0] {OP_NOP = 2'd0, OP_READ = 2'd1, OP_WRITE = 2'd2, OP_MRS = 2'd3} op_type_e;
  typedef struct packed {
    op_type_e    op_type;
    logic [1:0]  data_type;
    logic [15:0] row_addr;
    logic [9:0]  col_addr;
  } frontend_command_t;
  localparam int FRONTEND_CMD_BITS = $bits(frontend_command_t);
endpackage

module frontend_mem_responder
  import frontend_pkg::*;
#(
  parameter int ROW_W           = 4,
  parameter int COL_W           = 4,
  parameter int DATA_W          = `DQ_BITS * 8,
  parameter int READ_LATENCY    = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CMD_GAP         = 0,
  parameter int REFRESH_PERIOD  = 256,
  parameter int REFRESH_CYCLES  = 16
) (
  input  logic                         clk,
  input  logic                         power_on_rst_n,
  input  logic [FRONTEND_CMD_BITS-1:0] command,
  input  logic                         valid,
  input  logic [DATA_W-1:0]            write_data,
  output logic                         ba_cmd_pm,
  output logic [DATA_W-1:0]            read_data,
  output logic                         read_data_valid
);
  localparam int AW      = ROW_W + COL_W;
  localparam int CNT_MAX = CMD_GAP > REFRESH_CYCLES ? CMD_GAP : REFRESH_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int OW      = $clog2(MAX_OUTSTANDING + 1);
  localparam int RW      = REFRESH_PERIOD > 1 ? $clog2(REFRESH_PERIOD) : 1;
  typedef enum logic [1:0] {READY, GAP, REFRESH} state_e;

  frontend_command_t                     cmd;
  state_e                                state_q, state_d;
  logic [CW-1:0]                         cnt_q, cnt_d;
  logic [OW-1:0]                         outs_q, outs_d;
  logic [RW-1:0]                         rtim_q, rtim_d;
  logic                                  ref_pend_q, ref_pend_d;
  logic                                  ready_q, ready_d;
  logic                                  rd_valid_q;
  logic [DATA_W-1:0]                     rd_data_q;
  logic [READ_LATENCY-1:0]               pv_q;
  logic [READ_LATENCY-1:0][DATA_W-1:0]   pd_q;
  logic [DATA_W-1:0]                     mem [2**AW];
  logic [AW-1:0]                         addr;
  logic                                  acc, rd_acc, wr_acc, wrap, gap_done, ref_done, unused_cmd;

  assign cmd        = frontend_command_t'(command);
  assign unused_cmd = ^cmd;
  assign addr       = {cmd.row_addr[ROW_W-1:0], cmd.col_addr[COL_W-1:0]};
  assign acc        = valid && ready_q;
  assign rd_acc     = acc && cmd.op_type == OP_READ;
  assign wr_acc     = acc && cmd.op_type == OP_WRITE;
  assign wrap       = REFRESH_PERIOD != 0 && rtim_q == RW'(REFRESH_PERIOD - 1);
  assign gap_done   = cnt_q == CW'(CMD_GAP - 1);
  assign ref_done   = cnt_q == CW'(REFRESH_CYCLES - 1);

  always_comb begin
    state_d    = state_q == READY ? (ref_pend_q ? REFRESH : (acc && CMD_GAP > 0) ? GAP : READY)
               : state_q == GAP   ? (!gap_done ? GAP : ref_pend_q ? REFRESH : READY)
               : (ref_done ? READY : REFRESH);
    cnt_d      = (state_d == state_q && state_q != READY) ? cnt_q + 1'b1 : '0;
    // a wrap arriving while a refresh is already pending is intentionally lost
    ref_pend_d = (state_q == REFRESH && ref_done) ? 1'b0 : (ref_pend_q || wrap);
    rtim_d     = (REFRESH_PERIOD == 0 || wrap) ? '0 : rtim_q + 1'b1;
    outs_d     = outs_q + OW'(rd_acc) - OW'(rd_valid_q);
    ready_d    = state_d == READY && !ref_pend_d && outs_d < OW'(MAX_OUTSTANDING);
  end

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      state_q    <= READY;
      cnt_q      <= '0;
      outs_q     <= '0;
      rtim_q     <= '0;
      ref_pend_q <= 1'b0;
      ready_q    <= 1'b0;
      pv_q       <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      outs_q     <= outs_d;
      rtim_q     <= rtim_d;
      ref_pend_q <= ref_pend_d;
      ready_q    <= ready_d;
      pv_q       <= READ_LATENCY'({pv_q, rd_acc});
      rd_valid_q <= pv_q[READ_LATENCY-1];
      if (pv_q[READ_LATENCY-1]) rd_data_q <= pd_q[READ_LATENCY-1];
    end
  end

  // array and data pipeline carry no reset so contents survive a mid-run reset
  always_ff @(posedge clk) begin
    if (wr_acc) mem[addr] <= write_data;
    pd_q <= (READ_LATENCY * DATA_W)'({pd_q, mem[addr]});
  end

  assign ba_cmd_pm       = ready_q;
  assign read_data       = rd_data_q;
  assign read_data_valid = rd_valid_q;
endmodule

// File: tb/tb_frontend_mem_responder.sv
// tb_frontend_mem_responder: directed checks of write/read-back, read-after-write, credit limit,
// gap/refresh stalls and mid-flight reset across three differently parameterised responders.
`ifndef DQ_BITS
`define DQ_BITS 8
`endif
module tb_frontend_mem_responder;
  import frontend_pkg::*;
  localparam int DW = `DQ_BITS * 8;
  typedef struct {int cyc; logic [DW-1:0] d;} ret_t;

  logic                         clk = 1'b0, rst_n = 1'b0;
  logic [FRONTEND_CMD_BITS-1:0] cmd_a, cmd_b, cmd_c;
  logic                         valid_a, valid_b, valid_c;
  logic [DW-1:0]                wd_a, wd_b, wd_c, rd_a, rd_b, rd_c;
  logic                         rdy_a, rdy_b, rdy_c, rdv_a, rdv_b, rdv_c;
  int                           cyc = 0, tests_run = 0, tests_failed = 0, e0 = 0;
  ret_t                         qa[$], qb[$], qc[$];

  frontend_mem_responder u_a (
    .clk(clk), .power_on_rst_n(rst_n), .command(cmd_a), .valid(valid_a), .write_data(wd_a),
    .ba_cmd_pm(rdy_a), .read_data(rd_a), .read_data_valid(rdv_a));
  frontend_mem_responder #(.MAX_OUTSTANDING(2), .READ_LATENCY(6), .REFRESH_PERIOD(0)) u_b (
    .clk(clk), .power_on_rst_n(rst_n), .command(cmd_b), .valid(valid_b), .write_data(wd_b),
    .ba_cmd_pm(rdy_b), .read_data(rd_b), .read_data_valid(rdv_b));
  frontend_mem_responder #(.CMD_GAP(2), .REFRESH_PERIOD(32), .REFRESH_CYCLES(5)) u_c (
    .clk(clk), .power_on_rst_n(rst_n), .command(cmd_c), .valid(valid_c), .write_data(wd_c),
    .ba_cmd_pm(rdy_c), .read_data(rd_c), .read_data_valid(rdv_c));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rdv_a) qa.push_back(ret_t'{cyc, rd_a});
    if (rdv_b) qb.push_back(ret_t'{cyc, rd_b});
    if (rdv_c) qc.push_back(ret_t'{cyc, rd_c});
  end

  function automatic logic [FRONTEND_CMD_BITS-1:0] mk(input op_type_e op, input int row, input int col);
    frontend_command_t c;
    c = '{op_type: op, data_type: 2'b10, row_addr: 16'(row), col_addr: 10'(col)};
    return c;
  endfunction

  task automatic do_reset();
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    @(posedge clk); #1; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; e0 = cyc;
    qa.delete(); qb.delete(); qc.delete();
  endtask

  task automatic send_a(input op_type_e op, input int row, input int col, input logic [DW-1:0] d, output int e);
    int n = 0;
    cmd_a = mk(op, row, col); wd_a = d; valid_a = 1'b1;
    while (!rdy_a && n < 50) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (!rdy_a) begin tests_failed++; $display("FAIL send_a ready timeout after %0d cycles", n); end
    @(posedge clk); #1; e = cyc; valid_a = 1'b0;
  endtask

  task automatic send_b(input op_type_e op, input int row, input int col, input logic [DW-1:0] d, output int e);
    int n = 0;
    cmd_b = mk(op, row, col); wd_b = d; valid_b = 1'b1;
    while (!rdy_b && n < 50) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (!rdy_b) begin tests_failed++; $display("FAIL send_b ready timeout after %0d cycles", n); end
    @(posedge clk); #1; e = cyc; valid_b = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    tests_run++;
    if ({rdy_a, rdy_b, rdy_c} !== 3'b000) begin tests_failed++; $display("FAIL reset_ready got %b want 000", {rdy_a, rdy_b, rdy_c}); end
    tests_run++;
    if ({rdv_a, rdv_b, rdv_c} !== 3'b000) begin tests_failed++; $display("FAIL reset_rdv got %b want 000", {rdv_a, rdv_b, rdv_c}); end
    tests_run++;
    if ({rd_a, rd_b, rd_c} !== '0) begin tests_failed++; $display("FAIL reset_rdata got %h %h %h want 0", rd_a, rd_b, rd_c); end
    @(posedge clk); #1; rst_n = 1'b1;
    tests_run++;
    if (rdy_a !== 1'b0) begin tests_failed++; $display("FAIL ready_before_edge got %b want 0", rdy_a); end
    @(posedge clk); #1;
    tests_run++;
    if ({rdy_a, rdy_b, rdy_c} !== 3'b111) begin tests_failed++; $display("FAIL ready_first_edge got %b want 111", {rdy_a, rdy_b, rdy_c}); end
  endtask

  task automatic test_write_readback();
    int e, acc[16];
    do_reset();
    for (int r = 0; r < 16; r++) send_a(OP_WRITE, r, 0, DW'(r * 16), e);
    // upper address bits set on reads must be ignored
    for (int r = 0; r < 16; r++) send_a(OP_READ, r | 'hA0, 'h30, '0, acc[r]);
    repeat (8) @(posedge clk);
    #1;
    tests_run++;
    if (qa.size() != 16) begin tests_failed++; $display("FAIL wr_rd_count got %0d want 16", qa.size()); end
    for (int i = 0; i < 16 && i < qa.size(); i++) begin
      tests_run++;
      if (qa[i].d !== DW'(i * 16)) begin tests_failed++; $display("FAIL wr_rd_data[%0d] got %h want %h", i, qa[i].d, i * 16); end
      tests_run++;
      if (qa[i].cyc != acc[i] + 4) begin tests_failed++; $display("FAIL wr_rd_latency[%0d] got %0d want %0d", i, qa[i].cyc, acc[i] + 4); end
      tests_run++;
      if (acc[i] != acc[0] + i) begin tests_failed++; $display("FAIL wr_rd_b2b[%0d] got %0d want %0d", i, acc[i], acc[0] + i); end
    end
  endtask

  task automatic test_raw_and_nop();
    int t0, t1, t2, t3;
    do_reset();
    send_a(OP_WRITE, 3, 2, 'hA5, t0);
    send_a(OP_READ, 3, 2, '0, t1);
    send_a(OP_NOP, 3, 2, 'hFF, t2);
    send_a(OP_READ, 3, 2, '0, t3);
    repeat (8) @(posedge clk);
    #1;
    tests_run++;
    if (t1 != t0 + 1) begin tests_failed++; $display("FAIL raw_b2b got %0d want %0d", t1, t0 + 1); end
    tests_run++;
    if (qa.size() != 2) begin tests_failed++; $display("FAIL raw_count got %0d want 2", qa.size()); end
    if (qa.size() == 2) begin
      tests_run++;
      if (qa[0].d !== DW'('hA5)) begin tests_failed++; $display("FAIL raw_data got %h want a5", qa[0].d); end
      tests_run++;
      if (qa[0].cyc != t1 + 4) begin tests_failed++; $display("FAIL raw_latency got %0d want %0d", qa[0].cyc, t1 + 4); end
      tests_run++;
      if (qa[1].d !== DW'('hA5)) begin tests_failed++; $display("FAIL nop_no_effect got %h want a5", qa[1].d); end
    end
    tests_run++;
    if (rdv_a !== 1'b0 || rd_a !== DW'('hA5)) begin tests_failed++; $display("FAIL rdata_hold got v=%b d=%h want v=0 d=a5", rdv_a, rd_a); end
  endtask

  task automatic test_credit_limit();
    int e, k, n, cnt, maxin, acc[8];
    bit pre, post[8];
    do_reset();
    for (int i = 0; i < 8; i++) send_b(OP_WRITE, 0, i, DW'('h100 + i), e);
    cmd_b = mk(OP_READ, 0, 0); valid_b = 1'b1; k = 0; n = 0;
    while (k < 8 && n < 200) begin
      pre = rdy_b;
      @(posedge clk); #1; n++;
      if (pre) begin acc[k] = cyc; post[k] = rdy_b; k++; cmd_b = mk(OP_READ, 0, k); end
    end
    valid_b = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    tests_run++;
    if (k != 8) begin tests_failed++; $display("FAIL credit_accepts got %0d want 8", k); end
    tests_run++;
    if (post[0] !== 1'b1 || post[1] !== 1'b0) begin tests_failed++; $display("FAIL credit_ready_fall got %b%b want 10", post[0], post[1]); end
    for (int i = 1; i < k; i++) begin
      tests_run++;
      if (acc[i] != acc[0] + (i / 2) * 8 + i % 2) begin tests_failed++; $display("FAIL credit_spacing[%0d] got %0d want %0d", i, acc[i] - acc[0], (i / 2) * 8 + i % 2); end
    end
    tests_run++;
    if (qb.size() != 8) begin tests_failed++; $display("FAIL credit_returns got %0d want 8", qb.size()); end
    maxin = 0;
    for (int i = 0; i < 8 && i < qb.size(); i++) begin
      tests_run++;
      if (qb[i].d !== DW'('h100 + i) || qb[i].cyc != acc[i] + 6) begin
        tests_failed++; $display("FAIL credit_ret[%0d] got %h@%0d want %h@%0d", i, qb[i].d, qb[i].cyc, 'h100 + i, acc[i] + 6);
      end
      cnt = 0;
      for (int j = 0; j <= i; j++) if (qb[j].cyc >= acc[i]) cnt++;
      if (cnt > maxin) maxin = cnt;
    end
    tests_run++;
    if (maxin != 2) begin tests_failed++; $display("FAIL credit_max_outstanding got %0d want 2", maxin); end
  endtask

  task automatic test_gap_refresh();
    int acc[$], exp[$], run, best;
    bit pre, tr[71];
    for (int m = 0; m <= 10; m++) exp.push_back(2 + 3 * m);
    for (int m = 0; m <= 8; m++) exp.push_back(40 + 3 * m);
    do_reset();
    cmd_c = mk(OP_READ, 1, 1); wd_c = '0; valid_c = 1'b1;
    for (int n = 1; n <= 70; n++) begin
      pre = rdy_c;
      @(posedge clk); #1;
      if (pre) acc.push_back(n);
      tr[n] = rdy_c;
    end
    valid_c = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    tests_run++;
    if (acc.size() != 20) begin tests_failed++; $display("FAIL gap_accepts got %0d want 20", acc.size()); end
    for (int i = 0; i < 20 && i < acc.size(); i++) begin
      tests_run++;
      if (acc[i] != exp[i]) begin tests_failed++; $display("FAIL gap_accept_edge[%0d] got %0d want %0d", i, acc[i], exp[i]); end
    end
    tests_run++;
    if (qc.size() != 20) begin tests_failed++; $display("FAIL gap_returns got %0d want 20", qc.size()); end
    for (int i = 0; i < 20 && i < qc.size(); i++) begin
      tests_run++;
      if (qc[i].cyc - e0 != exp[i] + 4) begin tests_failed++; $display("FAIL gap_return_edge[%0d] got %0d want %0d", i, qc[i].cyc - e0, exp[i] + 4); end
    end
    run = 0; best = 0;
    for (int n = 1; n <= 70; n++) begin run = tr[n] ? 0 : run + 1; if (run > best) best = run; end
    tests_run++;
    if (best < 5) begin tests_failed++; $display("FAIL refresh_window got %0d want >=5", best); end
    tests_run++;
    if (tr[36] !== 1'b0) begin tests_failed++; $display("FAIL return_in_window ready got %b want 0", tr[36]); end
  endtask

  task automatic test_midflight_reset();
    int e;
    do_reset();
    send_a(OP_READ, 1, 0, '0, e);
    send_a(OP_READ, 2, 0, '0, e);
    send_a(OP_READ, 3, 0, '0, e);
    // write held while not ready must leave the array untouched
    cmd_a = mk(OP_WRITE, 5, 0); wd_a = 'hDEAD; valid_a = 1'b1;
    rst_n = 1'b0; #1;
    tests_run++;
    if (rdv_a !== 1'b0 || rdy_a !== 1'b0 || rd_a !== '0) begin tests_failed++; $display("FAIL midreset_outputs got v=%b r=%b d=%h want 0 0 0", rdv_a, rdy_a, rd_a); end
    repeat (6) @(posedge clk);
    #1;
    tests_run++;
    if (qa.size() != 0) begin tests_failed++; $display("FAIL midreset_discard got %0d returns want 0", qa.size()); end
    valid_a = 1'b0; rst_n = 1'b1; qa.delete();
    send_a(OP_READ, 5, 0, '0, e);
    repeat (8) @(posedge clk);
    #1;
    tests_run++;
    if (qa.size() != 1) begin tests_failed++; $display("FAIL midreset_single_return got %0d want 1", qa.size()); end
    else begin
      tests_run++;
      if (qa[0].d !== DW'(80) || qa[0].cyc != e + 4) begin tests_failed++; $display("FAIL midreset_retained got %h@%0d want 50@%0d", qa[0].d, qa[0].cyc, e + 4); end
    end
  endtask

  initial begin
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_c = '0; wd_a = '0; wd_b = '0; wd_c = '0;
    test_reset();
    test_write_readback();
    test_raw_and_nop();
    test_credit_limit();
    test_gap_refresh();
    test_midflight_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/frontend_mem_responder.md
# frontend_mem_responder

Synthesizable responder for the frontend command interface: accepts `frontend_command_t` commands with write data over the `valid`/`ba_cmd_pm` handshake, stores writes in an internal row×column array, and returns read data in order on `read_data`/`read_data_valid` after a fixed latency. It stands in for the full command scheduler and DRAM backend during bring-up of frontend masters and the command pattern bench. It models backend stalls through a command gap, an outstanding-read limit, and periodic refresh windows.

## Interface
- `ROW_W`, 4: row address bits used; upper `row_addr` bits are ignored.
- `COL_W`, 4: column address bits used; upper `col_addr` bits are ignored.
- `DATA_W`, `` `DQ_BITS*8 ``: data word width.
- `READ_LATENCY`, 4: cycles from read accept to `read_data_valid`; must be ≥1.
- `MAX_OUTSTANDING`, 8: maximum number of reads accepted but not yet returned; must be ≥1.
- `CMD_GAP`, 0: forced not-ready cycles after each accepted command.
- `REFRESH_PERIOD`, 256: cycles between refresh windows; 0 disables refresh.
- `REFRESH_CYCLES`, 16: length of each refresh window; must be ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `power_on_rst_n` in 1: asynchronous active-low reset.
- `command` in `FRONTEND_CMD_BITS`: `frontend_command_t` (`op_type`, `data_type`, `row_addr`, `col_addr`).
- `valid` in 1: command and `write_data` are valid.
- `write_data` in `DATA_W`: write payload, qualified by `valid` with `op_type==OP_WRITE`.
- `ba_cmd_pm` out 1: ready; registered, no combinational path from any input.
- `read_data` out `DATA_W`: read return data.
- `read_data_valid` out 1: single-cycle strobe per returned read. There is no output backpressure.

## Operation
- **Accept rule:** a command is accepted at a rising edge where `valid && ba_cmd_pm`.
- **Address:** `addr = {row_addr[ROW_W-1:0], col_addr[COL_W-1:0]}`. The array holds 2^(ROW_W+COL_W) words and is not reset.
- **OP_WRITE:** `mem[addr] <= write_data` at the accept edge.
- **OP_READ:** `mem[addr]` is sampled at the accept edge, after all previously accepted writes have taken effect, and pushed into a READ_LATENCY-deep shift pipeline with a valid bit.
- **Other op_type:** accepted with no effect. `data_type` is ignored.
- **Outstanding counter `outs`, range 0..MAX_OUTSTANDING:**
  - +1 on read accept.
  - −1 when the pipeline emits a return.
  - Both in the same cycle: unchanged.
- **State machine:**
  - **READY:**
    - Go to REFRESH if `ref_pending` is set.
    - Otherwise go to GAP on accept when CMD_GAP>0.
    - Otherwise stay.
  - **GAP:** count CMD_GAP cycles, then go to REFRESH if `ref_pending` is set, else READY.
  - **REFRESH:** count REFRESH_CYCLES cycles, clear `ref_pending`, then go to READY.
- **Refresh timer:** a free-running counter over 0..REFRESH_PERIOD-1. On wrap it sets `ref_pending`. A wrap while `ref_pending` is already set is dropped and not queued.
- **Ready computation:** `ba_cmd_pm` is registered from next-cycle values: `next_state==READY && !next_ref_pending && next_outs < MAX_OUTSTANDING`. Over-accepting past MAX_OUTSTANDING is therefore impossible.
- **Returns during stalls:** reads already in the pipeline continue to return during GAP and REFRESH.

## Timing
- **Reset values:** `ba_cmd_pm=0`, `read_data_valid=0`, `read_data=0`, state READY, `outs=0`, pipeline valids 0, refresh counter 0, `ref_pending=0`.
- **After reset release:** `ba_cmd_pm` rises at the first rising edge.
- **Read latency:** a read accepted at edge T drives `read_data_valid=1` with its data from edge T+READ_LATENCY for exactly one cycle.
- **`read_data` when idle:** holds its last value when `read_data_valid=0`.
- **Ordering:** returns are strictly in accept order; the pipeline never reorders.
- **Throughput with CMD_GAP=0:** one command per cycle, back-to-back, while `outs<MAX_OUTSTANDING`.
- **Throughput with CMD_GAP=g:** `ba_cmd_pm` is low for exactly g cycles after each accept.
- **Outstanding limit:** when the accept brings `outs` to MAX_OUTSTANDING, `ba_cmd_pm` is 0 in the next cycle. It returns to 1 the cycle after the return strobe that lowers `outs`.
- **Refresh window:** `ba_cmd_pm` is low for at least REFRESH_CYCLES consecutive cycles per window.
- **Mid-operation reset:**
  - All outputs return to their reset values immediately (asynchronously).
  - In-flight reads are discarded and never returned.
  - Array contents are retained.
- **Master holding `valid` while `ba_cmd_pm=0`:** no accept and no side effects.

## Test plan
- **Write/read-back:** reset, then write 16 rows × col 0 with `data=row*16+col`, then read the same 16 addresses → 16 `read_data_valid` strobes with data 0,16,…,240 in order, each READ_LATENCY cycles after its accept.
- **Read-after-write, same address:** write 0xA5 to (3,2) at edge T, read (3,2) at edge T+1 with CMD_GAP=0 → return 0xA5 at edge T+1+READ_LATENCY.
- **Credit limit:** MAX_OUTSTANDING=2, READ_LATENCY=6, continuous reads → `ba_cmd_pm` falls after the 2nd accept and rises one cycle after the first return; the total of 8 reads completes with `outs` never exceeding 2.
- **Gap and refresh:** CMD_GAP=2, REFRESH_PERIOD=32, REFRESH_CYCLES=5, continuous valid → accepts spaced 3 cycles apart, a ≥5-cycle ready-low window every 32 cycles, and returns still strobe inside the window.
- **Mid-flight reset:** assert reset with 3 reads in flight → `read_data_valid` stays 0 and `ba_cmd_pm=0` immediately. After release, a read of a previously written address returns the old data, and only that single return strobe is seen.
